// File: rtl/uart_sched_pkg.sv
// Shared constants, FSM encoding and CTRL2 packing for the UART APB TX scheduler.
// CoreUARTapb register map as seen from this APB master.
package uart_sched_pkg;

  localparam logic [4:0] ADDR_TXDATA = 5'h00;
  localparam logic [4:0] ADDR_CTRL1  = 5'h08;
  localparam logic [4:0] ADDR_CTRL2  = 5'h0C;
  localparam logic [4:0] ADDR_STATUS = 5'h10;

  localparam int TXRDY_BIT = 0;

  typedef enum logic [2:0] {
    S_CFG1,
    S_CFG2,
    S_IDLE,
    S_POLL,
    S_CHECK,
    S_WRITE
  } state_t;

  typedef enum logic [1:0] {
    PH_IDLE,
    PH_SETUP,
    PH_ACCESS
  } phase_t;

  function automatic logic [7:0] ctrl2_val(
    input logic [12:0] baud,
    input int          parity,
    input logic        bit8
  );
    return {baud[12:8], parity == 2, parity != 0, bit8};
  endfunction

endpackage

// File: rtl/uart_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after the pointer.
module uart_rr_arbiter
  import uart_sched_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_gnt,
  output logic [IW-1:0]   o_idx,
  output logic            o_valid
);

  logic [IW-1:0] w_j;

  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    w_j     = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_j = IW'((int'(i_ptr) + k) % NREQ);
      if (!o_valid && i_req[w_j]) begin
        o_valid    = 1'b1;
        o_gnt[w_j] = 1'b1;
        o_idx      = w_j;
      end
    end
  end

endmodule

// File: rtl/uart_apb_tx_scheduler.sv
// Configures a CoreUARTapb over APB, then shares its TX among NREQ requesters.
// Optional `UART_POLL_TIMEOUT_EN: bounded STATUS polling with sticky err.
module uart_apb_tx_scheduler
  import uart_sched_pkg::*;
#(
  parameter int          NREQ       = 4,
  parameter logic [12:0] BAUD_VALUE = 13'd1,
  parameter logic        PRG_BIT8   = 1'b1,
  parameter int          PRG_PARITY = 0,
  parameter int          POLL_LIMIT = 1023
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   ack,
  output logic              cfg_done,
  output logic              busy,
  output logic              err,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [4:0]        PADDR,
  output logic [7:0]        PWDATA,
  input  logic [7:0]        PRDATA,
  input  logic              PREADY
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t          r_state, w_state_nx, w_after;
  phase_t          r_ph, w_ph_nx;
  logic [IW-1:0]   r_ptr, r_idx, w_idx;
  logic [NREQ-1:0] r_gnt, r_ack, w_gnt, w_req;
  logic [7:0]      r_data;
  logic            r_txrdy, r_cfg_done, r_busy;
  logic            w_valid, w_grant, w_done, w_tmo, w_sel;
  logic            w_unused_prdata;

  assign w_unused_prdata = ^PRDATA;

  // The acked requester is masked for one cycle so it can drop req.
  assign w_req   = req & ~r_ack;
  assign w_grant = (r_state == S_IDLE) && r_cfg_done && w_valid;
  assign w_done  = (r_ph == PH_ACCESS) && PREADY;

  uart_rr_arbiter #(.NREQ(NREQ)) u_arb (
    .i_req   (w_req),
    .i_ptr   (r_ptr),
    .o_gnt   (w_gnt),
    .o_idx   (w_idx),
    .o_valid (w_valid)
  );

`ifdef UART_POLL_TIMEOUT_EN
  localparam int CW = $clog2(POLL_LIMIT + 1);

  logic [CW-1:0] r_cnt;
  logic          r_err;

  assign w_tmo = (r_state == S_CHECK) && !r_txrdy &&
                 (r_cnt == CW'(POLL_LIMIT));
  assign err   = r_err;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      if (w_grant)
        r_cnt <= '0;
      else if (r_state == S_POLL && w_done && !PRDATA[TXRDY_BIT])
        r_cnt <= r_cnt + CW'(1);
      if (w_tmo)
        r_err <= 1'b1;
    end
  end
`else
  assign w_tmo = 1'b0;
  assign err   = 1'b0;
`endif

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_state <= S_CFG1;
      r_ph    <= PH_IDLE;
    end else begin
      r_state <= w_state_nx;
      r_ph    <= w_ph_nx;
    end
  end

  always_comb begin
    unique case (r_state)
      S_CFG1:  w_after = S_CFG2;
      S_POLL:  w_after = S_CHECK;
      default: w_after = S_IDLE;
    endcase
  end

  always_comb begin
    w_state_nx = r_state;
    w_ph_nx    = r_ph;
    unique case (r_state)
      S_IDLE: begin
        if (w_grant) begin
          w_state_nx = S_POLL;
          w_ph_nx    = PH_SETUP;
        end
      end
      S_CHECK: begin
        if (r_txrdy) begin
          w_state_nx = S_WRITE;
          w_ph_nx    = PH_SETUP;
        end else if (w_tmo) begin
          w_state_nx = S_IDLE;
        end else begin
          w_state_nx = S_POLL;
          w_ph_nx    = PH_SETUP;
        end
      end
      default: begin
        unique case (r_ph)
          PH_IDLE:  w_ph_nx = PH_SETUP;
          PH_SETUP: w_ph_nx = PH_ACCESS;
          default: begin
            if (PREADY) begin
              w_ph_nx    = PH_IDLE;
              w_state_nx = w_after;
            end
          end
        endcase
      end
    endcase
  end

  // Address/data are forced to 0 whenever the bus is not selected.
  always_comb begin
    w_sel   = (r_ph != PH_IDLE);
    PSEL    = w_sel;
    PENABLE = (r_ph == PH_ACCESS);
    PWRITE  = 1'b0;
    PADDR   = '0;
    PWDATA  = '0;
    if (w_sel) begin
      unique case (r_state)
        S_CFG1: begin
          PWRITE = 1'b1;
          PADDR  = ADDR_CTRL1;
          PWDATA = BAUD_VALUE[7:0];
        end
        S_CFG2: begin
          PWRITE = 1'b1;
          PADDR  = ADDR_CTRL2;
          PWDATA = ctrl2_val(BAUD_VALUE, PRG_PARITY, PRG_BIT8);
        end
        S_POLL: PADDR = ADDR_STATUS;
        S_WRITE: begin
          PWRITE = 1'b1;
          PADDR  = ADDR_TXDATA;
          PWDATA = r_data;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_ptr      <= '0;
      r_idx      <= '0;
      r_gnt      <= '0;
      r_ack      <= '0;
      r_data     <= '0;
      r_txrdy    <= 1'b0;
      r_cfg_done <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_ack <= '0;
      if (w_grant) begin
        r_idx  <= w_idx;
        r_gnt  <= w_gnt;
        r_data <= req_data[{w_idx, 3'b000} +: 8];
        r_busy <= 1'b1;
      end
      if (r_state == S_POLL && w_done)
        r_txrdy <= PRDATA[TXRDY_BIT];
      if (r_state == S_CFG2 && w_done)
        r_cfg_done <= 1'b1;
      if ((r_state == S_WRITE && w_done) || w_tmo) begin
        r_ack  <= r_gnt;
        r_busy <= 1'b0;
        r_ptr  <= (r_idx == IW'(NREQ - 1)) ? '0 : r_idx + IW'(1);
      end
    end
  end

  assign ack      = r_ack;
  assign busy     = r_busy;
  assign cfg_done = r_cfg_done;

endmodule
